decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
// - Registered RV32I decode stage between fetch and the ALU/execute stage.
// - Successor to the purely combinational decoder. Adds four things:
//   - an immediate generator for all five formats;
//   - per-opcode operand muxing (rs1/PC/zero, rs2/imm/4);
//   - an illegal-instruction flag;
//   - a one-entry output pipeline register with valid/ready handshake and flush.
// - Register-file read addresses stay combinational from the incoming instruction.
// PARAMETERS
// - OPD_LENGTH  32  width of opd1/opd2/imm/store_data
// - REG_WIDTH   32  width of rs1_data/rs2_data from register file
// - PC_WIDTH    32  width of pc input; zero-extended to OPD_LENGTH
// PORTS
// - clk         in   1           rising-edge clock
// - rst_n       in   1           asynchronous active-low reset
// - in_valid    in   1           fetch presents instr/pc
// - in_ready    out  1           stage accepts this cycle
// - instr       in   32          instruction word
// - pc          in   PC_WIDTH    address of instr
// - flush       in   1           kill held and incoming instruction
// - rs1_addr    out  5           instr[19:15], combinational
// - rs2_addr    out  5           instr[24:20], combinational
// - rs1_data    in   REG_WIDTH   register file read data (same cycle)
// - rs2_data    in   REG_WIDTH   register file read data (same cycle)
// - out_valid   out  1           registered outputs hold a decoded instr
// - out_ready   in   1           execute consumes this cycle
// - rd_addr     out  5           destination register
// - rd_we       out  1           write-back enable
// - opd1        out  OPD_LENGTH  ALU operand 1
// - opd2        out  OPD_LENGTH  ALU operand 2
// - imm         out  OPD_LENGTH  sign-extended immediate (branch/JALR/store offset)
// - store_data  out  OPD_LENGTH  rs2_data zero-extended, for stores
// - funct3      out  3           instr[14:12]
// - opcode      out  7           instr[6:0]
// - illegal     out  1           unsupported encoding
// BEHAVIOUR
// - Reset: all registered outputs and out_valid = 0. Reset is async-assert, sync-release, and applies mid-transfer too.
// - in_ready = !out_valid | out_ready (combinational).
//   - Accept = in_valid & in_ready & !flush.
//   - Accepted instr appears on the registered outputs the next cycle. Latency = 1.
// - Hold: while out_valid & !out_ready, all outputs are stable and no new accept occurs.
// - Flush has priority. Next cycle out_valid = 0. An instruction offered in the flush cycle is dropped.
// - Consume without accept: out_valid & out_ready & !accept -> out_valid = 0 next cycle.
// - Consume with accept: the new instruction is loaded in the same cycle (back-to-back throughput 1/clk).
// - Immediates (sign-extended from instr[31]):
//   - I: [31:20]
//   - S: {[31:25],[11:7]}
//   - B: {[31],[7],[30:25],[11:8],0}
//   - U: {[31:12],12'b0}
//   - J: {[31],[19:12],[20],[30:21],0}
// - Operand mux by opcode:
//
//   | Opcode      | Value   | opd1      | opd2   | imm / note                    |
//   |-------------|---------|-----------|--------|-------------------------------|
//   | LUI         | 0110111 | 0         | imm_U  |                               |
//   | AUIPC       | 0010111 | pc        | imm_U  |                               |
//   | JAL         | 1101111 | pc        | 4      | imm = imm_J                   |
//   | JALR        | 1100111 | pc        | 4      | imm = imm_I (target from rs1) |
//   | BRANCH      | 1100011 | rs1       | rs2    | imm = imm_B                   |
//   | LOAD/OP-IMM | —       | rs1       | imm_I  |                               |
//   | STORE       | —       | rs1       | imm_S  |                               |
//   | OP          | —       | rs1       | rs2    |                               |
//   | MISC-MEM, SYSTEM | —  | 0         | 0      |                               |
//
// - rd_we = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd_addr != 0. Otherwise 0.
// - illegal = 1 when any of:
//   - instr[1:0] != 2'b11;
//   - unlisted opcode;
//   - JALR with funct3 != 0.
//   When illegal = 1: rd_we is forced to 0, the instr still passes with out_valid = 1, and opd1 = opd2 = 0.
// - Width rules: rs*_data and pc are zero-extended or truncated to OPD_LENGTH. The immediate is sign-extended to OPD_LENGTH.
// STRUCTURE
// - Shared include header holds:
//   - opcode localparams (OPC_LUI … OPC_SYSTEM);
//   - immediate-format codes;
//   - the constant 4 for link.
// - Sub-module imm_gen: combinational; instr -> imm_I/S/B/U/J, or one selected imm plus format select.
// - Top level holds the operand/illegal decode and the single pipeline register.
// TESTING
// - Reset then addi x1,x0,5 (0x00500093), rs1_data=0 -> next cycle:
//   - out_valid = 1, rd_addr = 1, rd_we = 1;
//   - opd1 = 0, opd2 = 5.
// - lui x2,0x12345 (0x12345137) -> opd1 = 0, opd2 = 0x12345000, rd_we = 1.
//   - beq x1,x2,-8 (0xFE208CE3) -> opd1 = rs1_data, opd2 = rs2_data, imm = 0xFFFFFFF8, rd_we = 0.
// - Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 ->
//   - in_ready = 0;
//   - outputs stable;
//   - on release, the next instr is loaded with no bubble.
// - flush during a hold and with in_valid = 1 -> out_valid = 0 next cycle; the offered instr never appears.
// - instr = 0x00000000 -> illegal = 1, rd_we = 0, out_valid = 1.
//   - addi x0,x0,0 (0x00000013) -> rd_we = 0, illegal = 0.
//   - rst_n low mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - RV32I opcodes, immediate formats and link constant for the decode stage
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  localparam int unsigned LINK_OFFSET = 4;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// rtl/decode_stage_imm_gen.sv - combinational RV32I immediate generator with format select
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0] i_instr,
  input  imm_fmt_e    i_fmt,
  output logic [31:0] o_imm
);

  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  always_comb begin
    o_imm = '0;
    case (i_fmt)
      IMM_I:   o_imm = w_imm_i;
      IMM_S:   o_imm = w_imm_s;
      IMM_B:   o_imm = w_imm_b;
      IMM_U:   o_imm = w_imm_u;
      IMM_J:   o_imm = w_imm_j;
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode: operand muxing, illegal detect, one-entry valid/ready output stage
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int OPD_LENGTH = 32,
  parameter int REG_WIDTH  = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic                  flush,
  output logic [4:0]            rs1_addr,
  output logic [4:0]            rs2_addr,
  input  logic [REG_WIDTH-1:0]  rs1_data,
  input  logic [REG_WIDTH-1:0]  rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            rd_addr,
  output logic                  rd_we,
  output logic [OPD_LENGTH-1:0] opd1,
  output logic [OPD_LENGTH-1:0] opd2,
  output logic [OPD_LENGTH-1:0] imm,
  output logic [OPD_LENGTH-1:0] store_data,
  output logic [2:0]            funct3,
  output logic [6:0]            opcode,
  output logic                  illegal
);

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [4:0]            w_rd;
  imm_fmt_e              w_fmt;
  logic [31:0]           w_imm_raw;
  logic [OPD_LENGTH-1:0] w_imm_ext;
  logic [OPD_LENGTH-1:0] w_rs1_ext;
  logic [OPD_LENGTH-1:0] w_rs2_ext;
  logic [OPD_LENGTH-1:0] w_pc_ext;
  logic [OPD_LENGTH-1:0] w_link;
  logic [OPD_LENGTH-1:0] w_opd1_raw;
  logic [OPD_LENGTH-1:0] w_opd2_raw;
  logic                  w_we_raw;
  logic                  w_illegal;
  logic [OPD_LENGTH-1:0] w_opd1;
  logic [OPD_LENGTH-1:0] w_opd2;
  logic [OPD_LENGTH-1:0] w_imm;
  logic                  w_rd_we;
  logic                  w_accept;

  logic                  r_valid;
  logic [4:0]            r_rd_addr;
  logic                  r_rd_we;
  logic [OPD_LENGTH-1:0] r_opd1;
  logic [OPD_LENGTH-1:0] r_opd2;
  logic [OPD_LENGTH-1:0] r_imm;
  logic [OPD_LENGTH-1:0] r_store_data;
  logic [2:0]            r_funct3;
  logic [6:0]            r_opcode;
  logic                  r_illegal;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_rd     = instr[11:7];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign w_link   = OPD_LENGTH'(LINK_OFFSET);

  generate
    if (REG_WIDTH >= OPD_LENGTH) begin : g_reg_trunc
      assign w_rs1_ext = rs1_data[OPD_LENGTH-1:0];
      assign w_rs2_ext = rs2_data[OPD_LENGTH-1:0];
    end else begin : g_reg_zext
      assign w_rs1_ext = {{(OPD_LENGTH-REG_WIDTH){1'b0}}, rs1_data};
      assign w_rs2_ext = {{(OPD_LENGTH-REG_WIDTH){1'b0}}, rs2_data};
    end
    if (PC_WIDTH >= OPD_LENGTH) begin : g_pc_trunc
      assign w_pc_ext = pc[OPD_LENGTH-1:0];
    end else begin : g_pc_zext
      assign w_pc_ext = {{(OPD_LENGTH-PC_WIDTH){1'b0}}, pc};
    end
    if (OPD_LENGTH <= 32) begin : g_imm_trunc
      assign w_imm_ext = w_imm_raw[OPD_LENGTH-1:0];
    end else begin : g_imm_sext
      assign w_imm_ext = {{(OPD_LENGTH-32){w_imm_raw[31]}}, w_imm_raw};
    end
  endgenerate

  // Format select is kept apart from the operand mux so imm never feeds back into its own select.
  always_comb begin
    w_fmt = IMM_NONE;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC:              w_fmt = IMM_U;
      OPC_JAL:                         w_fmt = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:  w_fmt = IMM_I;
      OPC_BRANCH:                      w_fmt = IMM_B;
      OPC_STORE:                       w_fmt = IMM_S;
      default:                         w_fmt = IMM_NONE;
    endcase
  end

  decode_stage_imm_gen u_imm_gen (
    .i_instr (instr),
    .i_fmt   (w_fmt),
    .o_imm   (w_imm_raw)
  );

  always_comb begin
    w_opd1_raw = '0;
    w_opd2_raw = '0;
    w_we_raw   = 1'b0;
    w_illegal  = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_opd2_raw = w_imm_ext;
        w_we_raw   = 1'b1;
      end
      OPC_AUIPC: begin
        w_opd1_raw = w_pc_ext;
        w_opd2_raw = w_imm_ext;
        w_we_raw   = 1'b1;
      end
      OPC_JAL: begin
        w_opd1_raw = w_pc_ext;
        w_opd2_raw = w_link;
        w_we_raw   = 1'b1;
      end
      OPC_JALR: begin
        w_opd1_raw = w_pc_ext;
        w_opd2_raw = w_link;
        w_we_raw   = 1'b1;
        w_illegal  = (w_funct3 != 3'b000);
      end
      OPC_BRANCH, OPC_OP: begin
        w_opd1_raw = w_rs1_ext;
        w_opd2_raw = w_rs2_ext;
        w_we_raw   = (w_opcode == OPC_OP);
      end
      OPC_LOAD, OPC_OP_IMM: begin
        w_opd1_raw = w_rs1_ext;
        w_opd2_raw = w_imm_ext;
        w_we_raw   = 1'b1;
      end
      OPC_STORE: begin
        w_opd1_raw = w_rs1_ext;
        w_opd2_raw = w_imm_ext;
      end
      OPC_MISC_MEM, OPC_SYSTEM: begin
        w_opd1_raw = '0;
        w_opd2_raw = '0;
      end
      default: w_illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end
  end

  // Illegal encodings still flow downstream so execute can trap, but carry no side effects.
  assign w_opd1  = w_illegal ? '0 : w_opd1_raw;
  assign w_opd2  = w_illegal ? '0 : w_opd2_raw;
  assign w_imm   = w_illegal ? '0 : w_imm_ext;
  assign w_rd_we = w_we_raw & ~w_illegal & (w_rd != 5'd0);

  assign in_ready = ~r_valid | out_ready;
  assign w_accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_we      <= 1'b0;
      r_opd1       <= '0;
      r_opd2       <= '0;
      r_imm        <= '0;
      r_store_data <= '0;
      r_funct3     <= '0;
      r_opcode     <= '0;
      r_illegal    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid      <= 1'b1;
      r_rd_addr    <= w_rd;
      r_rd_we      <= w_rd_we;
      r_opd1       <= w_opd1;
      r_opd2       <= w_opd2;
      r_imm        <= w_imm;
      r_store_data <= w_rs2_ext;
      r_funct3     <= w_funct3;
      r_opcode     <= w_opcode;
      r_illegal    <= w_illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign rd_addr    = r_rd_addr;
  assign rd_we      = r_rd_we;
  assign opd1       = r_opd1;
  assign opd2       = r_opd2;
  assign imm        = r_imm;
  assign store_data = r_store_data;
  assign funct3     = r_funct3;
  assign opcode     = r_opcode;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic [31:0] opd1;
  logic [31:0] opd2;
  logic [31:0] imm;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic [6:0]  opcode;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  decode_stage #(
    .OPD_LENGTH (32),
    .REG_WIDTH  (32),
    .PC_WIDTH   (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .pc         (pc),
    .flush      (flush),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .rd_addr    (rd_addr),
    .rd_we      (rd_we),
    .opd1       (opd1),
    .opd2       (opd2),
    .imm        (imm),
    .store_data (store_data),
    .funct3     (funct3),
    .opcode     (opcode),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    instr     = 32'h0;
    pc        = 32'h0;
    flush     = 1'b0;
    rs1_data  = 32'h0;
    rs2_data  = 32'h0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_rd_we", {31'b0, rd_we}, 32'h0);
    chk("rst_opd2", opd2, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    rst_n = 1'b1;
    step();

    // addi x1,x0,5
    instr = 32'h00500093; pc = 32'h100; in_valid = 1'b1; rs1_data = 32'h0; rs2_data = 32'h77;
    #1;
    chk("addi_rs2_addr", {27'b0, rs2_addr}, 32'd5);
    step();
    chk("addi_valid", {31'b0, out_valid}, 32'h1);
    chk("addi_rd", {27'b0, rd_addr}, 32'd1);
    chk("addi_we", {31'b0, rd_we}, 32'h1);
    chk("addi_opd1", opd1, 32'h0);
    chk("addi_opd2", opd2, 32'd5);
    chk("addi_illegal", {31'b0, illegal}, 32'h0);

    // lui x2,0x12345
    instr = 32'h12345137; rs1_data = 32'hDEAD0000;
    step();
    chk("lui_opd1", opd1, 32'h0);
    chk("lui_opd2", opd2, 32'h12345000);
    chk("lui_we", {31'b0, rd_we}, 32'h1);
    chk("lui_rd", {27'b0, rd_addr}, 32'd2);

    // beq x1,x2,-8
    instr = 32'hFE208CE3; rs1_data = 32'hAAAA0001; rs2_data = 32'h55550002;
    #1;
    chk("beq_rs1_addr", {27'b0, rs1_addr}, 32'd1);
    chk("beq_rs2_addr", {27'b0, rs2_addr}, 32'd2);
    step();
    chk("beq_opd1", opd1, 32'hAAAA0001);
    chk("beq_opd2", opd2, 32'h55550002);
    chk("beq_imm", imm, 32'hFFFFFFF8);
    chk("beq_we", {31'b0, rd_we}, 32'h0);
    chk("beq_opcode", {25'b0, opcode}, 32'h63);

    // auipc x3,0x1 at pc 0x200
    instr = 32'h00001197; pc = 32'h200;
    step();
    chk("auipc_opd1", opd1, 32'h200);
    chk("auipc_opd2", opd2, 32'h1000);
    chk("auipc_we", {31'b0, rd_we}, 32'h1);

    // jal x1,+8 at pc 0x300
    instr = 32'h008000EF; pc = 32'h300;
    step();
    chk("jal_opd1", opd1, 32'h300);
    chk("jal_opd2", opd2, 32'd4);
    chk("jal_imm", imm, 32'd8);

    // sw x2,12(x1)
    instr = 32'h0020A623; rs1_data = 32'h1000; rs2_data = 32'hCAFEBABE;
    step();
    chk("sw_opd1", opd1, 32'h1000);
    chk("sw_opd2", opd2, 32'd12);
    chk("sw_store_data", store_data, 32'hCAFEBABE);
    chk("sw_we", {31'b0, rd_we}, 32'h0);
    chk("sw_funct3", {29'b0, funct3}, 32'd2);

    // jalr with funct3=1 is illegal
    instr = 32'h000010E7; pc = 32'h400;
    step();
    chk("jalr_bad_illegal", {31'b0, illegal}, 32'h1);
    chk("jalr_bad_we", {31'b0, rd_we}, 32'h0);
    chk("jalr_bad_opd1", opd1, 32'h0);
    chk("jalr_bad_valid", {31'b0, out_valid}, 32'h1);

    // consume without accept
    in_valid = 1'b0;
    step();
    chk("drain_valid", {31'b0, out_valid}, 32'h0);

    // backpressure: addi x3,x0,7 held while addi x4,x0,9 waits
    rs1_data = 32'h0;
    instr = 32'h00700193; in_valid = 1'b1;
    step();
    out_ready = 1'b0;
    instr = 32'h00900213;
    #1;
    chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_hold_rd", {27'b0, rd_addr}, 32'd3);
      chk("bp_hold_opd2", opd2, 32'd7);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("bp_next_valid", {31'b0, out_valid}, 32'h1);
    chk("bp_next_rd", {27'b0, rd_addr}, 32'd4);
    chk("bp_next_opd2", opd2, 32'd9);

    // flush during a hold with a new instr offered
    out_ready = 1'b0;
    instr = 32'h00B00293; flush = 1'b1;
    step();
    chk("flush_valid", {31'b0, out_valid}, 32'h0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_dropped", {31'b0, out_valid}, 32'h0);

    // all-zero word is illegal
    instr = 32'h00000000; in_valid = 1'b1; rs1_data = 32'h12345678;
    step();
    chk("zero_illegal", {31'b0, illegal}, 32'h1);
    chk("zero_we", {31'b0, rd_we}, 32'h0);
    chk("zero_valid", {31'b0, out_valid}, 32'h1);

    // nop: rd=x0 so no write
    instr = 32'h00000013; rs1_data = 32'h0;
    step();
    chk("nop_we", {31'b0, rd_we}, 32'h0);
    chk("nop_illegal", {31'b0, illegal}, 32'h0);
    chk("nop_valid", {31'b0, out_valid}, 32'h1);

    // reset asserted mid-hold clears everything at once
    instr = 32'h00500093;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    step();
    chk("prehold_opd2", opd2, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_rd", {27'b0, rd_addr}, 32'h0);
    chk("midrst_opd2", opd2, 32'h0);
    chk("midrst_we", {31'b0, rd_we}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
